// File: rtl/jk_excitation_driver.sv
// Board top: steers a JK flip-flop model so Q tracks an 8-bit switch pattern, one step per button press.
// Optional macro JK_DRIVER_TOGGLE_EN resolves excitation don't-cares to 1 (uses JK=11 toggles).
module jk_excitation_driver #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned DEB_CYC     = CLK_HZ / 1000 * DEBOUNCE_MS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw_pin,
  input  logic        btn_0,
  input  logic        btn_1,
  output logic [15:0] led_pin
);

  localparam int unsigned CW   = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned LAST = (DEB_CYC > 0) ? DEB_CYC - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, DRIVE, APPLY} state_t;

  logic [1:0]         sync_1, sync_2, deb, pulse;
  logic [1:0][CW-1:0] cnt;
  logic               load_p, step_p;

  state_t     state;
  logic [7:0] pat_r;
  logic [2:0] idx;
  logic       q_m, j_r, k_r, wrap_r;
  logic       q_nxt;
  logic [2:0] idx_nxt;

  // Bit 0 is load/restart, bit 1 is step; pulse fires on the debounced rising edge only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      deb    <= '0;
      pulse  <= '0;
      cnt    <= '0;
    end else begin
      sync_1 <= {btn_1, btn_0};
      sync_2 <= sync_1;
      pulse  <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync_2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(LAST)) begin
          cnt[i]   <= '0;
          deb[i]   <= sync_2[i];
          pulse[i] <= sync_2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign load_p = pulse[0];
  assign step_p = pulse[1];

  function automatic logic [1:0] excite(input logic q, input logic t);
`ifdef JK_DRIVER_TOGGLE_EN
    return (q != t) ? 2'b11 : 2'b00;
`else
    return {~q & t, q & ~t};
`endif
  endfunction

  always_comb begin
    q_nxt   = q_m;
    idx_nxt = idx + 3'd1;
    case ({j_r, k_r})
      2'b01:   q_nxt = 1'b0;
      2'b10:   q_nxt = 1'b1;
      2'b11:   q_nxt = ~q_m;
      default: q_nxt = q_m;
    endcase
  end

  // J/K are refreshed on LOAD and APPLY too, so a step right after either never sees stale values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pat_r  <= '0;
      idx    <= '0;
      q_m    <= 1'b0;
      j_r    <= 1'b0;
      k_r    <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_p) state <= LOAD;
        end
        LOAD: begin
          pat_r      <= sw_pin;
          idx        <= '0;
          q_m        <= 1'b0;
          wrap_r     <= 1'b0;
          {j_r, k_r} <= excite(1'b0, sw_pin[0]);
          state      <= DRIVE;
        end
        DRIVE: begin
          {j_r, k_r} <= excite(q_m, pat_r[idx]);
          if (load_p)      state <= LOAD;
          else if (step_p) state <= APPLY;
        end
        APPLY: begin
          q_m        <= q_nxt;
          idx        <= idx_nxt;
          {j_r, k_r} <= excite(q_nxt, pat_r[idx_nxt]);
          if (idx == 3'd7) wrap_r <= 1'b1;
          state <= load_p ? LOAD : DRIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign led_pin = {pat_r, wrap_r, idx, pat_r[idx], q_m, j_r, k_r};

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Randomized/directed bench for jk_excitation_driver against a step-level model of the Q-tracking behaviour.
module tb_jk_excitation_driver;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 10 * DEB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw_pin;
  logic        btn_0, btn_1;
  logic [15:0] led_pin;

  int errors = 0;
  int checks = 0;

  // Model: pattern, position, flip-flop value, wrapped flag
  logic [7:0] m_pat;
  int         m_idx;
  logic       m_q;
  logic       m_wrap;

  jk_excitation_driver #(.DEB_CYC(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .sw_pin(sw_pin),
    .btn_0(btn_0), .btn_1(btn_1), .led_pin(led_pin)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // J sets a rising target, K clears a falling one; toggle mode drives both whenever Q must change.
  function automatic logic [15:0] exp_led();
    logic t, j, k, differ;
    t = m_pat[m_idx];
    differ = (m_q != t);
`ifdef JK_DRIVER_TOGGLE_EN
    j = differ;
    k = differ;
`else
    j = differ && t;
    k = differ && !t;
`endif
    return {m_pat, m_wrap, 3'(m_idx), t, m_q, j, k};
  endfunction

  task automatic m_reset();
    m_pat = '0; m_idx = 0; m_q = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic m_load(input logic [7:0] p);
    m_pat = p; m_idx = 0; m_q = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic m_step();
    m_q = m_pat[m_idx];
    if (m_idx == 7) m_wrap = 1'b1;
    m_idx = (m_idx + 1) % 8;
  endtask

  task automatic press(input logic ld, input logic st);
    btn_0 = ld; btn_1 = st;
    tick(HOLD);
    btn_0 = 1'b0; btn_1 = 1'b0;
    tick(HOLD);
  endtask

  initial begin
    logic [15:0] l;
    logic [1:0]  jk_exp;
    rst_n = 1'b0; sw_pin = 8'hA5; btn_0 = 1'b0; btn_1 = 1'b0;
    m_reset();

    // Reset with buttons toggling
    for (int i = 0; i < 3; i++) begin
      btn_0 = i[0]; btn_1 = ~i[0];
      tick(1);
    end
    chk("reset_hold", led_pin, 16'h0000);
    btn_0 = 1'b0; btn_1 = 1'b0; rst_n = 1'b1;
    tick(2);
    chk("reset_release", led_pin, 16'h0000);
    press(1'b0, 1'b1);
    chk("idle_step_ignored", led_pin, 16'h0000);

    // Directed B2 walk
    sw_pin = 8'hB2;
    press(1'b1, 1'b0);
    m_load(8'hB2);
    chk("load_b2", led_pin, exp_led());
    chk("load_b2_fields", led_pin, {8'hB2, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00});
    sw_pin = 8'h3C;
    press(1'b0, 1'b1); m_step();
    l = led_pin;
`ifdef JK_DRIVER_TOGGLE_EN
    chk("b2_step1", l, {8'hB2, 1'b0, 3'd1, 1'b1, 1'b0, 2'b11});
`else
    chk("b2_step1", l, {8'hB2, 1'b0, 3'd1, 1'b1, 1'b0, 2'b10});
`endif
    press(1'b0, 1'b1); m_step();
`ifdef JK_DRIVER_TOGGLE_EN
    chk("b2_step2", led_pin, {8'hB2, 1'b0, 3'd2, 1'b0, 1'b1, 2'b11});
`else
    chk("b2_step2", led_pin, {8'hB2, 1'b0, 3'd2, 1'b0, 1'b1, 2'b01});
`endif
    press(1'b0, 1'b1); m_step();
    chk("b2_step3", led_pin, {8'hB2, 1'b0, 3'd3, 1'b0, 1'b0, 2'b00});
    for (int s = 3; s < 8; s++) begin
      press(1'b0, 1'b1);
      chk("b2_q_follows", {15'd0, led_pin[2]}, {15'd0, m_pat[m_idx]});
      m_step();
      chk("b2_walk", led_pin, exp_led());
    end
    chk("wrap_set", {15'd0, led_pin[7]}, 16'd1);
    chk("wrap_idx0", {13'd0, led_pin[6:4]}, 16'd0);
    sw_pin = 8'hB2;
    press(1'b1, 1'b0); m_load(8'hB2);
    chk("wrap_cleared", led_pin, exp_led());

    // Bounce shorter than the debounce window, then a long hold
    for (int g = 0; g < 4; g++) begin
      btn_1 = 1'b1; tick(DEB - 2);
      btn_1 = 1'b0; tick(DEB - 2);
    end
    chk("bounce_no_step", led_pin, exp_led());
    press(1'b0, 1'b1); m_step();
    chk("bounce_one_step", led_pin, exp_led());

    // Simultaneous load+step at idx 5
    while (m_idx != 5) begin
      press(1'b0, 1'b1); m_step();
    end
    chk("pre_simul_idx5", led_pin, exp_led());
    sw_pin = 8'h0F;
    press(1'b1, 1'b1); m_load(8'h0F);
    chk("simul_load_wins", led_pin, exp_led());
    chk("simul_fields", {led_pin[15:8], 1'b0, led_pin[6:4], 1'b0, led_pin[2], 2'b00},
        {8'h0F, 1'b0, 3'd0, 1'b0, 1'b0, 2'b00});

    // 0x55 exercises the toggle/no-toggle excitation difference
    sw_pin = 8'h55;
    press(1'b1, 1'b0); m_load(8'h55);
    for (int s = 0; s < 8; s++) begin
`ifdef JK_DRIVER_TOGGLE_EN
      jk_exp = 2'b11;
`else
      jk_exp = (s % 2 == 0) ? 2'b10 : 2'b01;
`endif
      chk("p55_jk", {14'd0, led_pin[1:0]}, {14'd0, jk_exp});
      press(1'b0, 1'b1); m_step();
      chk("p55_q", {15'd0, led_pin[2]}, (s % 2 == 0) ? 16'd1 : 16'd0);
    end

    // Random patterns, step counts and post-load switch noise
    for (int r = 0; r < 6; r++) begin
      logic [7:0] p;
      int n;
      p = 8'($urandom);
      sw_pin = p;
      press(1'b1, 1'b0); m_load(p);
      chk("rand_load", led_pin, exp_led());
      n = int'($urandom_range(1, 10));
      for (int s = 0; s < n; s++) begin
        sw_pin = 8'($urandom);
        press(1'b0, 1'b1); m_step();
        chk("rand_step", led_pin, exp_led());
      end
    end

    // Reset mid-operation, then confirm IDLE ignores steps
    rst_n = 1'b0; tick(1);
    m_reset();
    chk("midop_reset", led_pin, 16'h0000);
    rst_n = 1'b1;
    press(1'b0, 1'b1);
    chk("midop_idle", led_pin, exp_led());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
